downcount_ctrl: RTL

//  Controller and sequencer for the 4-bit down-counter datapath. It loads a start

---
 rtl/downcount_ctrl.sv | 90 +++++++++
 1 files changed

// File: rtl/downcount_ctrl.sv
// Sequencer for a prescaled 4-bit down-counter: load, count down, pause,
// stop, auto-reload, plus terminal-count pulse and done flag.
module downcount_ctrl #(
  parameter int WIDTH    = 4,
  parameter int PS_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    cfg_load_val,
  input  logic [PS_WIDTH-1:0] cfg_prescale,
  input  logic                cfg_auto_reload,
  input  logic                start,
  input  logic                hold,
  input  logic                stop,
  output logic [WIDTH-1:0]    count,
  output logic                busy,
  output logic                tc_pulse,
  output logic                done,
  output logic                start_err
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    count_nxt;
  logic [PS_WIDTH-1:0] pcnt, pcnt_nxt;
  logic                tc_nxt, err_nxt;
  logic                active;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      count     <= '1;
      pcnt      <= '0;
      tc_pulse  <= 1'b0;
      start_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      pcnt      <= pcnt_nxt;
      tc_pulse  <= tc_nxt;
      start_err <= err_nxt;
    end
  end

  // A PAUSE with hold released is treated like RUN on that same edge, so a
  // hold of N clocks delays the countdown by exactly N clocks.
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    pcnt_nxt  = pcnt;
    tc_nxt    = 1'b0;
    err_nxt   = 1'b0;
    active    = (state == RUN) || (state == PAUSE);

    if (stop) begin
      state_nxt = IDLE;
    end else if (start && !active) begin
      count_nxt = cfg_load_val;
      pcnt_nxt  = cfg_prescale;
      state_nxt = RUN;
    end else if (active) begin
      err_nxt = start;
      if (hold) begin
        state_nxt = PAUSE;
      end else begin
        state_nxt = RUN;
        if (pcnt != '0) begin
          pcnt_nxt = pcnt - PS_WIDTH'(1);
        end else begin
          pcnt_nxt = cfg_prescale;
          if (count != '0) begin
            count_nxt = count - WIDTH'(1);
          end else begin
            // Zero is trapped here, so the counter can never wrap
            tc_nxt = 1'b1;
            if (cfg_auto_reload) count_nxt = cfg_load_val;
            else                 state_nxt = DONE;
          end
        end
      end
    end
  end

  always_comb begin
    busy = (state == RUN) || (state == PAUSE);
    done = (state == DONE);
  end

endmodule
